// File: rtl/kbest_layer_sched_pkg.sv
// Shared types and defaults for the K-best layer scheduler.
package kbest_layer_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StExpand,
        StWaitC,
        StEnum,
        StDone
    } ks_state_e;

    localparam int unsigned KS_NUM_LAYER_DEF = 4;
    localparam int unsigned KS_TIMEOUT_DEF   = 64;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned ks_cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/kbest_layer_sched_dn_timer.sv
// Loadable down-counter shared by the expansion timeout and the enumeration wait.
module kbest_layer_sched_dn_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // Final cycle of the current count: the next decrement reaches zero.
    assign last = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/kbest_layer_sched.sv
// K-best detector layer sequencer: walks one frame through all tree layers, top layer first,
// driving expansion, enumeration and survivor-capture strobes.
module kbest_layer_sched
    import kbest_layer_sched_pkg::*;
#(
    parameter int unsigned NUM_LAYER = KS_NUM_LAYER_DEF,
    parameter int unsigned ENUM_LAT  = 1,
    parameter int unsigned TIMEOUT   = KS_TIMEOUT_DEF,
    parameter int unsigned LW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    output logic [LW-1:0] lyr_idx,
    output logic          surv_init,
    output logic          exp_en,
    input  logic          cand_valid,
    output logic          enum_launch,
    output logic          surv_we,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err,
    output logic          busy,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned TW = ks_cnt_width(TIMEOUT);

    ks_state_e     state_q, state_d;
    logic [LW-1:0] lyr_q, lyr_d;
    logic          surv_init_q, surv_init_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          start_ready_q, busy_q, exp_en_q, out_valid_q;
    logic          err_q, err_d;
    logic          surv_we_q, surv_we_d;

    logic          tmr_load, tmr_en, tmr_last;
    logic [TW-1:0] tmr_val, tmr_cnt;
    logic          launch, layer_done;

    kbest_layer_sched_dn_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .last     (tmr_last)
    );

    assign launch = (state_q == StWaitC) && cand_valid;

    always_comb begin
        state_d     = state_q;
        lyr_d       = lyr_q;
        surv_init_d = surv_init_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = TW'(TIMEOUT);
        tmr_en      = 1'b0;
        layer_done  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_valid && start_ready_q) begin
                    lyr_d       = LW'(NUM_LAYER - 1);
                    surv_init_d = 1'b1;
                    state_d     = StExpand;
                end
            end
            StExpand: begin
                tmr_load = 1'b1;
                state_d  = StWaitC;
            end
            StWaitC: begin
                // A late cand_valid on the expiry cycle still counts.
                if (cand_valid) begin
                    if (ENUM_LAT == 0) begin
                        layer_done = 1'b1;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(ENUM_LAT);
                        state_d  = StEnum;
                    end
                end else if (tmr_last) begin
                    err_d       = 1'b1;
                    surv_init_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StEnum: begin
                if (tmr_last) begin
                    layer_done = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (layer_done) begin
            if (lyr_q == '0) begin
                state_d = StDone;
            end else begin
                lyr_d       = lyr_q - LW'(1);
                surv_init_d = 1'b0;
                state_d     = StExpand;
            end
        end
    end

    // Registered strobe lands on the final ENUM cycle, i.e. launch + ENUM_LAT.
    assign surv_we_d = (launch && (ENUM_LAT == 1)) ||
                       ((state_q == StEnum) && (tmr_cnt == TW'(2)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            lyr_q         <= '0;
            surv_init_q   <= 1'b0;
            frame_cnt_q   <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            exp_en_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            surv_we_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lyr_q         <= lyr_d;
            surv_init_q   <= surv_init_d;
            frame_cnt_q   <= frame_cnt_d;
            start_ready_q <= (state_d == StIdle);
            busy_q        <= (state_d != StIdle);
            exp_en_q      <= (state_d == StExpand);
            out_valid_q   <= (state_d == StDone);
            err_q         <= err_d;
            surv_we_q     <= surv_we_d;
        end
    end

    assign start_ready = start_ready_q;
    assign lyr_idx     = lyr_q;
    assign surv_init   = surv_init_q;
    assign exp_en      = exp_en_q;
    assign enum_launch = launch;
    assign surv_we     = (ENUM_LAT == 0) ? launch : surv_we_q;
    assign out_valid   = out_valid_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_kbest_layer_sched.sv
// Bench for kbest_layer_sched: per-cycle timeline model built from frame plans, checked on
// two instances (ENUM_LAT=1 and ENUM_LAT=0).
module tb_kbest_layer_sched;

    localparam int NL   = 4;
    localparam int TMO  = 64;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_valid = 1'b0;
    logic cand_valid  = 1'b0;
    logic out_ready   = 1'b0;
    logic sel = 1'b1;

    logic sr1, si1, exp1, lau1, we1, ov1, err1, busy1;
    logic sr0, si0, exp0, lau0, we0, ov0, err0, busy0;
    logic [1:0]  lyr1, lyr0;
    logic [15:0] fc1, fc0;

    logic o_sr, o_si, o_exp, o_lau, o_we, o_ov, o_err, o_busy;
    logic [1:0]  o_lyr;
    logic [15:0] o_fc;

    // Timeline model and stimulus, indexed by cycle within a test.
    bit e_exp [MAXC], e_lau [MAXC], e_we [MAXC], e_ov [MAXC], e_err [MAXC];
    bit e_busy [MAXC], e_si [MAXC], e_lyck [MAXC];
    int e_lyr [MAXC], e_fc [MAXC];
    bit s_start [MAXC], s_cand [MAXC], s_ord [MAXC];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int ov_first, n_exp_seen, n_we_seen;

    always #5 clk = ~clk;

    kbest_layer_sched #(.NUM_LAYER(4), .ENUM_LAT(1), .TIMEOUT(TMO), .LW(2)) dut1 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1), .lyr_idx(lyr1),
        .surv_init(si1), .exp_en(exp1), .cand_valid(cand_valid), .enum_launch(lau1),
        .surv_we(we1), .out_valid(ov1), .out_ready(out_ready), .err(err1), .busy(busy1),
        .frame_cnt(fc1)
    );

    kbest_layer_sched #(.NUM_LAYER(4), .ENUM_LAT(0), .TIMEOUT(TMO), .LW(2)) dut0 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0), .lyr_idx(lyr0),
        .surv_init(si0), .exp_en(exp0), .cand_valid(cand_valid), .enum_launch(lau0),
        .surv_we(we0), .out_valid(ov0), .out_ready(out_ready), .err(err0), .busy(busy0),
        .frame_cnt(fc0)
    );

    always_comb begin
        o_sr   = sel ? sr1   : sr0;
        o_si   = sel ? si1   : si0;
        o_exp  = sel ? exp1  : exp0;
        o_lau  = sel ? lau1  : lau0;
        o_we   = sel ? we1   : we0;
        o_ov   = sel ? ov1   : ov0;
        o_err  = sel ? err1  : err0;
        o_busy = sel ? busy1 : busy0;
        o_lyr  = sel ? lyr1  : lyr0;
        o_fc   = sel ? fc1   : fc0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", nm, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("exp_en",      32'(o_exp),  32'(e_exp[cyc]));
            chk("enum_launch", 32'(o_lau),  32'(e_lau[cyc]));
            chk("surv_we",     32'(o_we),   32'(e_we[cyc]));
            chk("out_valid",   32'(o_ov),   32'(e_ov[cyc]));
            chk("err",         32'(o_err),  32'(e_err[cyc]));
            chk("busy",        32'(o_busy), 32'(e_busy[cyc]));
            chk("start_ready", 32'(o_sr),   32'(!e_busy[cyc]));
            chk("surv_init",   32'(o_si),   32'(e_si[cyc]));
            chk("frame_cnt",   32'(o_fc),   32'(e_fc[cyc]));
            if (e_lyck[cyc]) chk("lyr_idx", 32'(o_lyr), 32'(e_lyr[cyc]));
            if (o_exp) n_exp_seen++;
            if (o_we) n_we_seen++;
            if (o_ov && ov_first < 0) ov_first = cyc;
        end
    end

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            e_exp[c] = 0; e_lau[c] = 0; e_we[c] = 0; e_ov[c] = 0; e_err[c] = 0;
            e_busy[c] = 0; e_si[c] = 0; e_lyck[c] = 1; e_lyr[c] = 0; e_fc[c] = 0;
            s_start[c] = 0; s_cand[c] = 0; s_ord[c] = 1;
        end
        ov_first = -1; n_exp_seen = 0; n_we_seen = 0;
    endtask

    task automatic mark_busy(input int a, input int b, input int k, input bit si);
        for (int c = a; c <= b; c++) begin
            e_busy[c] = 1; e_lyr[c] = k; e_lyck[c] = 1; e_si[c] = si;
        end
    endtask

    // Frame accepted at c0; d<k> is the WAIT_C cycle offset of cand_valid for layer k
    // (negative = never, i.e. timeout); bp = cycles out_ready is held low in DONE.
    task automatic plan_frame(input int c0, input int lat, input int d3, input int d2,
                              input int d1, input int d0, input int bp, output int c_next);
        int d [NL];
        int te, tl, tw;
        bit aborted;
        d[3] = d3; d[2] = d2; d[1] = d1; d[0] = d0;
        aborted = 0;
        c_next = c0 + 1;
        s_start[c0] = 1;
        te = c0 + 1;
        for (int k = NL - 1; k >= 0; k--) begin
            e_exp[te] = 1;
            if (d[k] < 0) begin
                mark_busy(te, te + TMO, k, k == NL - 1);
                e_err[te + TMO + 1] = 1;
                for (int c = te + TMO + 1; c < MAXC; c++) e_lyck[c] = 0;
                c_next = te + TMO + 1;
                aborted = 1;
                break;
            end
            tl = te + 1 + d[k];
            tw = tl + lat;
            s_cand[tl] = 1; e_lau[tl] = 1; e_we[tw] = 1;
            mark_busy(te, tw, k, k == NL - 1);
            te = tw + 1;
        end
        if (!aborted) begin
            for (int c = te; c < MAXC; c++) begin e_lyr[c] = 0; e_lyck[c] = 1; end
            for (int c = te; c <= te + bp; c++) begin
                e_ov[c] = 1; e_busy[c] = 1; s_ord[c] = (c == te + bp);
            end
            for (int c = te + bp + 1; c < MAXC; c++) e_fc[c]++;
            c_next = te + bp + 1;
        end
    endtask

    task automatic run_test(input int n);
        for (int c = 0; c < n; c++) begin
            #1;
            start_valid = s_start[c]; cand_valid = s_cand[c]; out_ready = s_ord[c];
            cyc = c; chk_on = 1;
            @(negedge clk);
            @(posedge clk);
        end
        chk_on = 0;
        #1;
        start_valid = 0; cand_valid = 0; out_ready = 0;
    endtask

    task automatic check_zero();
        chk("rst_exp_en",      32'(o_exp),  0);
        chk("rst_enum_launch", 32'(o_lau),  0);
        chk("rst_surv_we",     32'(o_we),   0);
        chk("rst_out_valid",   32'(o_ov),   0);
        chk("rst_err",         32'(o_err),  0);
        chk("rst_busy",        32'(o_busy), 0);
        chk("rst_start_ready", 32'(o_sr),   0);
        chk("rst_surv_init",   32'(o_si),   0);
        chk("rst_lyr_idx",     32'(o_lyr),  0);
        chk("rst_frame_cnt",   32'(o_fc),   0);
    endtask

    task automatic do_reset();
        rst = 0; start_valid = 0; cand_valid = 0; out_ready = 0; chk_on = 0;
        repeat (2) @(posedge clk);
        #2;
        check_zero();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
    endtask

    function automatic int first_ov();
        for (int c = 0; c < MAXC; c++) if (e_ov[c]) return c;
        return -1;
    endfunction

    initial begin
        int cn, cn2;

        // 1: nominal, ENUM_LAT=1
        sel = 1; do_reset(); clear_plan();
        plan_frame(0, 1, 0, 0, 0, 0, 0, cn);
        chk("model_ov_cycle_lat1", first_ov(), 13);
        run_test(cn + 4);
        chk("nominal_ov_cycle", ov_first, 13);
        chk("nominal_exp_count", n_exp_seen, 4);
        chk("nominal_we_count", n_we_seen, 4);

        // 2: backpressure
        do_reset(); clear_plan();
        plan_frame(0, 1, 0, 0, 0, 0, 10, cn);
        run_test(cn + 4);

        // 3: timeout at layer 2, then a normal frame
        do_reset(); clear_plan();
        plan_frame(0, 1, 0, -1, 0, 0, 0, cn);
        plan_frame(cn + 1, 1, 0, 0, 0, 0, 0, cn2);
        run_test(cn2 + 3);

        // 4: cand_valid on the final timeout cycle
        do_reset(); clear_plan();
        plan_frame(0, 1, 0, TMO - 1, 1, 0, 0, cn);
        run_test(cn + 3);

        // 5: reset in ENUM of layer 1, then recovery
        do_reset(); clear_plan();
        plan_frame(0, 1, 0, 0, 0, 0, 0, cn);
        run_test(9);
        #2;
        chk("enum_l1_surv_we", 32'(o_we), 1);
        chk("enum_l1_lyr_idx", 32'(o_lyr), 1);
        rst = 0;
        #1;
        check_zero();
        do_reset(); clear_plan();
        plan_frame(3, 1, 1, 0, 0, 2, 0, cn);
        run_test(cn + 3);

        // 6a: spurious cand_valid / start_valid
        do_reset(); clear_plan();
        s_cand[0] = 1; s_cand[1] = 1;
        plan_frame(2, 1, 0, 2, 0, 0, 3, cn);
        for (int c = 0; c < MAXC; c++) begin
            if (e_busy[c]) s_start[c] = 1;
            if (e_we[c] || e_ov[c]) s_cand[c] = 1;
        end
        run_test(cn + 4);

        // 6b: nominal with ENUM_LAT=0
        sel = 0; do_reset(); clear_plan();
        plan_frame(0, 0, 0, 0, 0, 0, 0, cn);
        chk("model_ov_cycle_lat0", first_ov(), 9);
        run_test(cn + 4);
        chk("lat0_ov_cycle", ov_first, 9);
        chk("lat0_we_count", n_we_seen, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
